conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Sequencer for the 3×3 line-buffer convolution datapath. It walks the input image in raster order and issues one `shift_buffer` per pixel. It tracks the row and column of each pixel entering the line buffers, and raises `win_valid` with output coordinates whenever the buffers hold a complete window that lands on the selected stride grid. It sits between the top-level `start`/`done` handshake and the line buffers and MAC array, and replaces the ad-hoc shift control in the convolution top.

## Interface
- `COLS`, 28, image width in pixels
- `ROWS`, 28, image height in pixels
- `K`, 3, kernel size (fixed 3; the parameter exists for the width math only)
- `AW`, $clog2(ROWS*COLS), pixel address width
- `CW`, $clog2(ROWS), output coordinate width
---
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-low reset
- `start` input 1: begin a frame; sampled only in IDLE
- `stride` input 2: 1 or 2, latched on accepted `start`; 0 and 3 are illegal
- `stall` input 1: downstream backpressure; freezes pixel issue
- `shift_buffer` output 1: advance line buffers by one pixel this cycle
- `pix_addr` output AW: raster address of the pixel shifted this cycle
- `win_valid` output 1: line buffers hold a strided window (registered)
- `win_row` output CW: output row index of the current window
- `win_col` output CW: output column index of the current window
- `busy` output 1: high from accepted `start` until `done`
- `done` output 1: one-cycle pulse at frame end
- `err` output 1: one-cycle pulse on `start` with an illegal stride

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `start` is high and `stride` is 1 or 2. The stride is latched; all counters are cleared.
- IDLE with `start` high and `stride` at 0 or 3: `err` pulses for one cycle and the FSM stays in IDLE.
- In RUN, each cycle with `stall` low:
  - `shift_buffer` is 1 and `pix_addr` equals the pixel count.
  - `in_col` increments and wraps at COLS−1; `in_row` increments on that wrap.
- In RUN, `stall` high: `shift_buffer` is 0 and all counters hold.
- A window is complete on a shift when all of the following hold:
  - `in_row` ≥ K−1 and `in_col` ≥ K−1
  - (`in_row`−2) mod stride = 0
  - (`in_col`−2) mod stride = 0
- For a complete window, the next cycle has `win_valid` at 1, `win_row` = (`in_row`−2)/stride and `win_col` = (`in_col`−2)/stride.
- Use phase toggles for the stride-2 modulus, not dividers.
- RUN → DRAIN after the shift with `pix_addr` = ROWS*COLS−1. DRAIN lasts 1 cycle and exists only to let the last `win_valid` emerge.
- DRAIN → DONE: `done` is 1 for exactly one cycle, then the FSM returns to IDLE.
- `start` is ignored outside IDLE.
- Expected window count is ((ROWS−3)/stride+1)×((COLS−3)/stride+1): 676 for stride 1 and 169 for stride 2 at 28×28.

## Timing
- Reset values of all outputs: `shift_buffer`, `pix_addr`, `win_valid`, `win_row`, `win_col`, `busy`, `done` and `err` are all 0. The state resets to IDLE.
- Reset asserted mid-frame forces every output to its reset value immediately. No `done` is produced for the aborted frame.
- The first `shift_buffer` occurs in the cycle after the edge that samples `start`.
- `win_valid` lags its enabling shift by exactly 1 cycle and is a single-cycle pulse per window. It is never high in IDLE or DONE.
- `stall` raised in the cycle after a window-completing shift does not suppress that window's `win_valid`.
- No stall: `done` is high 786 cycles after the start-sampling edge for a 28×28 image (784 RUN + 1 DRAIN + 1 DONE). Each stalled cycle adds exactly 1.
- `busy` goes high the cycle after `start` is accepted and falls in the same cycle `done` rises.
- `start` high in the DONE cycle is not accepted; it is accepted only when sampled in IDLE.

## Structure
- Shared package `conv_pkg`:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - stride encodings `STRIDE_1` = 2'd1 and `STRIDE_2` = 2'd2
  - `K` = 3
  - default `ROWS`/`COLS`
- One sub-module: `raster_counter`, a row/column counter with enable, wrap and last-pixel flag. It is instantiated once for the input position.
- The stride-phase and output-coordinate logic stays in the parent.

## Test plan
- Stride 1, 28×28, no stall → 676 `win_valid` pulses. The first has `win_row`=0 and `win_col`=0, one cycle after the shift with `pix_addr`=58. The last has (25,25). `done` comes 786 cycles after start.
- Stride 2 → 169 pulses. Coordinates run 0..12 in both axes. The first is after `pix_addr`=58; the second is after `pix_addr`=60 with (0,1). `done` comes at 786.
- Stride 1, hold `stall` for 10 cycles mid-row at `pix_addr`=300 → `pix_addr` holds at 301 throughout, still 676 windows, `done` comes at 796.
- `start` with `stride`=0, then with `stride`=3 → `err` pulses once each, `busy` stays 0, no `shift_buffer`.
- Assert reset at `pix_addr`=400, release, then start again with stride 2 → all outputs 0 during reset, the new frame starts at `pix_addr`=0, 169 windows.
- `start` held high through the whole frame → exactly one frame runs. A second frame begins only after IDLE is re-entered, with its first shift 2 cycles after `done`.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;

  localparam int unsigned K        = 3;
  localparam int unsigned DEF_ROWS = 28;
  localparam int unsigned DEF_COLS = 28;

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Start/done handshake, backpressure and window-status bundle of the window sequencer.
interface conv_window_ctrl_if
  import conv_pkg::*;
#(
  parameter int unsigned AW = $clog2(DEF_ROWS * DEF_COLS),
  parameter int unsigned CW = $clog2(DEF_ROWS)
);
  logic          start;
  logic [1:0]    stride;
  logic          stall;
  logic          shift_buffer;
  logic [AW-1:0] pix_addr;
  logic          win_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  start, stride, stall,
    output shift_buffer, pix_addr, win_valid, win_row, win_col, busy, done, err
  );

  modport master (
    output start, stride, stall,
    input  shift_buffer, pix_addr, win_valid, win_row, win_col, busy, done, err
  );
endinterface

// File: rtl/conv_window_ctrl_raster_counter.sv
// Raster-order row/column/address counter; wraps to zero after the last pixel.
module raster_counter #(
  parameter int unsigned COLS = 28,
  parameter int unsigned ROWS = 28,
  parameter int unsigned AW   = $clog2(ROWS * COLS),
  parameter int unsigned RW   = $clog2(ROWS),
  parameter int unsigned CLW  = $clog2(COLS)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_clr,
  input  logic           i_en,
  output logic [CLW-1:0] o_col,
  output logic [RW-1:0]  o_row,
  output logic [AW-1:0]  o_addr,
  output logic           o_col_last,
  output logic           o_last
);
  localparam logic [CLW-1:0] COL_MAX = CLW'(COLS - 1);
  localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);

  logic [CLW-1:0] r_col;
  logic [RW-1:0]  r_row;
  logic [AW-1:0]  r_addr;
  logic           w_col_last;
  logic           w_last;

  assign w_col_last = (r_col == COL_MAX);
  assign w_last     = w_col_last && (r_row == ROW_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else if (w_col_last) begin
        r_col  <= '0;
        r_row  <= r_row + RW'(1);
        r_addr <= r_addr + AW'(1);
      end else begin
        r_col  <= r_col + CLW'(1);
        r_addr <= r_addr + AW'(1);
      end
    end
  end

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_addr     = r_addr;
  assign o_col_last = w_col_last;
  assign o_last     = w_last;
endmodule

// File: rtl/conv_window_ctrl.sv
// Raster-order shift sequencer for the 3x3 line buffers; flags strided windows with coordinates.
module conv_window_ctrl #(
  parameter int unsigned COLS = conv_pkg::DEF_COLS,
  parameter int unsigned ROWS = conv_pkg::DEF_ROWS,
  parameter int unsigned K    = conv_pkg::K,
  parameter int unsigned AW   = $clog2(ROWS * COLS),
  parameter int unsigned CW   = $clog2(ROWS)
) (
  input logic               i_clk,
  input logic               i_rst_n,
  conv_window_ctrl_if.slave bus
);
  import conv_pkg::*;

  localparam int unsigned    RW        = $clog2(ROWS);
  localparam int unsigned    CLW       = $clog2(COLS);
  localparam logic [RW-1:0]  ROW_FIRST = RW'(K - 1);
  localparam logic [CLW-1:0] COL_FIRST = CLW'(K - 1);

  state_e         r_state;
  state_e         w_state_nxt;
  logic           w_stride_ok;
  logic           w_shift;
  logic           w_clr;
  logic           w_win;
  logic           w_col_last;
  logic           w_last;
  logic           w_row_ge;
  logic           w_col_ge;
  logic [RW-1:0]  w_in_row;
  logic [CLW-1:0] w_in_col;
  logic [AW-1:0]  w_addr;

  logic           r_s2;
  logic           r_row_ph;
  logic           r_col_ph;
  logic [CW-1:0]  r_orow;
  logic [CW-1:0]  r_ocol;
  logic           r_win_valid;
  logic [CW-1:0]  r_win_row;
  logic [CW-1:0]  r_win_col;
  logic           r_err;

  raster_counter #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW),
    .RW   (RW),
    .CLW  (CLW)
  ) u_in_pos (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_clr),
    .i_en       (w_shift),
    .o_col      (w_in_col),
    .o_row      (w_in_row),
    .o_addr     (w_addr),
    .o_col_last (w_col_last),
    .o_last     (w_last)
  );

  assign w_stride_ok = (bus.stride == STRIDE_1) || (bus.stride == STRIDE_2);

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start && w_stride_ok) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          w_shift = 1'b1;
          if (w_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Phase bits track (pos-2) mod 2; the output index advances only when leaving phase 1.
  assign w_row_ge = (w_in_row >= ROW_FIRST);
  assign w_col_ge = (w_in_col >= COL_FIRST);
  assign w_win    = w_shift && w_row_ge && w_col_ge && (!r_s2 || (!r_row_ph && !r_col_ph));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2     <= 1'b0;
      r_row_ph <= 1'b0;
      r_col_ph <= 1'b0;
      r_orow   <= '0;
      r_ocol   <= '0;
    end else if (w_clr) begin
      r_s2     <= (bus.stride == STRIDE_2);
      r_row_ph <= 1'b0;
      r_col_ph <= 1'b0;
      r_orow   <= '0;
      r_ocol   <= '0;
    end else if (w_shift) begin
      if (w_col_last || !w_col_ge) begin
        r_col_ph <= 1'b0;
        r_ocol   <= '0;
      end else begin
        r_col_ph <= ~r_col_ph;
        if (!r_s2 || r_col_ph) r_ocol <= r_ocol + CW'(1);
      end
      if (w_col_last) begin
        if (w_last || !w_row_ge) begin
          r_row_ph <= 1'b0;
          r_orow   <= '0;
        end else begin
          r_row_ph <= ~r_row_ph;
          if (!r_s2 || r_row_ph) r_orow <= r_orow + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_win_valid <= w_win;
      if (w_win) begin
        r_win_row <= r_orow;
        r_win_col <= r_ocol;
      end
      r_err <= (r_state == IDLE) && bus.start && !w_stride_ok;
    end
  end

  assign bus.shift_buffer = w_shift;
  assign bus.pix_addr     = w_addr;
  assign bus.win_valid    = r_win_valid;
  assign bus.win_row      = r_win_row;
  assign bus.win_col      = r_win_col;
  assign bus.busy         = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done         = (r_state == DONE);
  assign bus.err          = r_err;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl: frame table plus scoreboard of expected windows.
module tb_conv_window_ctrl;
  localparam int ROWS = 28;
  localparam int COLS = 28;
  localparam int NPIX = ROWS * COLS;
  localparam int AW   = $clog2(ROWS * COLS);
  localparam int CW   = $clog2(ROWS);

  typedef struct {
    int cyc;
    int row;
    int col;
  } win_t;

  typedef struct {
    int stride;
    int stall_at;
    int stall_len;
    int abort_at;
    int exp_wins;
    int exp_done;
  } frame_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  win_t exp_q[$];

  conv_window_ctrl_if #(.AW(AW), .CW(CW)) bus ();

  conv_window_ctrl #(
    .COLS (COLS),
    .ROWS (ROWS),
    .K    (3),
    .AW   (AW),
    .CW   (CW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_shift"},     bus.shift_buffer, 0);
    check({tag, "_pix_addr"},  bus.pix_addr,     0);
    check({tag, "_win_valid"}, bus.win_valid,    0);
    check({tag, "_win_row"},   bus.win_row,      0);
    check({tag, "_win_col"},   bus.win_col,      0);
    check({tag, "_busy"},      bus.busy,         0);
    check({tag, "_done"},      bus.done,         0);
    check({tag, "_err"},       bus.err,          0);
  endtask

  // Drives one frame; cycle 1 is the cycle after the edge that samples start.
  task automatic run_frame(input frame_t f, input bit hold);
    int   m_pix, stall_left, wins, last_r, last_c, pr, pc;
    bit   seen_done;
    win_t w;
    exp_q.delete();
    m_pix      = 0;
    stall_left = f.stall_len;
    wins       = 0;
    last_r     = -1;
    last_c     = -1;
    seen_done  = 1'b0;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.stride = 2'(f.stride);
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= f.exp_done + 4 && !seen_done; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      bus.stall = (f.stall_at >= 0) && (m_pix == f.stall_at + 1) && (stall_left > 0);
      if (bus.stall) stall_left--;
      @(negedge clk);
      if (m_pix < NPIX) begin
        check("busy_run", bus.busy, 1);
        check("shift_buffer", bus.shift_buffer, !bus.stall);
        check("pix_addr", bus.pix_addr, m_pix);
      end else begin
        check("shift_after_frame", bus.shift_buffer, 0);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
        check("win_missing_cycle", exp_q[0].cyc, c);
        void'(exp_q.pop_front());
      end
      if (bus.win_valid) begin
        wins++;
        last_r = bus.win_row;
        last_c = bus.win_col;
        if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
          w = exp_q.pop_front();
          check("win_row", bus.win_row, w.row);
          check("win_col", bus.win_col, w.col);
        end else begin
          check("win_unexpected_cycle", c, (exp_q.size() > 0) ? exp_q[0].cyc : -1);
        end
      end
      if (f.abort_at >= 0 && m_pix == f.abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort_rst");
        bus.stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("abort_hold");
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", bus.done, 0);
          check("abort_no_busy", bus.busy, 0);
        end
        exp_q.delete();
        return;
      end
      if (m_pix < NPIX && !bus.stall) begin
        pr = m_pix / COLS;
        pc = m_pix % COLS;
        if (pr >= 2 && pc >= 2 && (pr - 2) % f.stride == 0 && (pc - 2) % f.stride == 0) begin
          w.cyc = c + 1;
          w.row = (pr - 2) / f.stride;
          w.col = (pc - 2) / f.stride;
          exp_q.push_back(w);
        end
        m_pix++;
      end
      if (bus.done) begin
        seen_done = 1'b1;
        check("done_cycle", c, f.exp_done);
        check("busy_at_done", bus.busy, 0);
        check("win_at_done", bus.win_valid, 0);
      end
    end
    bus.stall = 1'b0;
    check("done_seen", seen_done, 1);
    check("win_count", wins, f.exp_wins);
    check("last_win_row", last_r, (ROWS - 3) / f.stride);
    check("last_win_col", last_c, (COLS - 3) / f.stride);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic err_test(input int s);
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.stride = 2'(s);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.stride = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("err_first_cycle", bus.err, 1);
      pulses += int'(bus.err);
      check("err_busy", bus.busy, 0);
      check("err_shift", bus.shift_buffer, 0);
    end
    check("err_pulses", pulses, 1);
  endtask

  frame_t frames[5];
  int     err_strides[2];
  frame_t hold_f;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    frames[0] = '{stride: 1, stall_at: -1,  stall_len: 0,  abort_at: -1,  exp_wins: 676,
                  exp_done: 786};
    frames[1] = '{stride: 2, stall_at: -1,  stall_len: 0,  abort_at: -1,  exp_wins: 169,
                  exp_done: 786};
    frames[2] = '{stride: 1, stall_at: 300, stall_len: 10, abort_at: -1,  exp_wins: 676,
                  exp_done: 796};
    frames[3] = '{stride: 1, stall_at: -1,  stall_len: 0,  abort_at: 400, exp_wins: 0,
                  exp_done: 786};
    frames[4] = '{stride: 2, stall_at: -1,  stall_len: 0,  abort_at: -1,  exp_wins: 169,
                  exp_done: 786};
    err_strides[0] = 0;
    err_strides[1] = 3;
    hold_f = '{stride: 1, stall_at: -1, stall_len: 0, abort_at: -1, exp_wins: 676,
               exp_done: 786};

    bus.start  = 1'b0;
    bus.stride = 2'd1;
    bus.stall  = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    for (int i = 0; i < 5; i++) run_frame(frames[i], 1'b0);
    for (int i = 0; i < 2; i++) err_test(err_strides[i]);

    // start held through the frame: DONE must not accept it, IDLE must.
    run_frame(hold_f, 1'b1);
    @(negedge clk);
    check("hold_idle_shift", bus.shift_buffer, 0);
    check("hold_idle_busy", bus.busy, 0);
    @(negedge clk);
    check("hold_restart_shift", bus.shift_buffer, 1);
    check("hold_restart_addr", bus.pix_addr, 0);
    check("hold_restart_busy", bus.busy, 1);
    bus.start = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
